// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (instruction fetch / load-store) for one fixed-latency
// single-port memory. Data side has priority, bounded by a fetch starvation counter.
//
// state | meaning
// IDLE  | no access in flight; arbitrate on the requests seen at the next edge
// ISSUE | memory strobe for the latched winner, winner's gnt pulses
// WAIT  | counting down the memory latency; read data captured on the last cycle
// RESP  | owner's valid pulses
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_valid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [CNT_W-1:0]  starve_cnt, starve_nxt;
  logic              own_dm, own_dm_nxt;
  logic              lat_we, lat_we_nxt;
  logic [ADDR_W-1:0] lat_addr, lat_addr_nxt;
  logic [DATA_W-1:0] lat_wdata, lat_wdata_nxt;

  logic              if_gnt_nxt, if_valid_nxt, dm_gnt_nxt, dm_valid_nxt;
  logic              mem_en_nxt, mem_we_nxt, busy_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [DATA_W-1:0] mem_wdata_nxt, if_rdata_nxt, dm_rdata_nxt;

  // State, datapath latches and all registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      starve_cnt <= '0;
      own_dm     <= 1'b0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      if_gnt     <= 1'b0;
      if_valid   <= 1'b0;
      if_rdata   <= '0;
      dm_gnt     <= 1'b0;
      dm_valid   <= 1'b0;
      dm_rdata   <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      starve_cnt <= starve_nxt;
      own_dm     <= own_dm_nxt;
      lat_we     <= lat_we_nxt;
      lat_addr   <= lat_addr_nxt;
      lat_wdata  <= lat_wdata_nxt;
      if_gnt     <= if_gnt_nxt;
      if_valid   <= if_valid_nxt;
      if_rdata   <= if_rdata_nxt;
      dm_gnt     <= dm_gnt_nxt;
      dm_valid   <= dm_valid_nxt;
      dm_rdata   <= dm_rdata_nxt;
      mem_en     <= mem_en_nxt;
      mem_we     <= mem_we_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_wdata  <= mem_wdata_nxt;
      busy       <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    starve_nxt    = starve_cnt;
    own_dm_nxt    = own_dm;
    lat_we_nxt    = lat_we;
    lat_addr_nxt  = lat_addr;
    lat_wdata_nxt = lat_wdata;
    case (state)
      IDLE: begin
        if (if_req || dm_req) begin
          state_nxt = ISSUE;
          // starve_cnt < STARVE_MAX here, so the increment cannot pass the limit
          if (dm_req && (!if_req || (starve_cnt < CNT_W'(STARVE_MAX)))) begin
            own_dm_nxt    = 1'b1;
            lat_we_nxt    = dm_we;
            lat_addr_nxt  = dm_addr;
            lat_wdata_nxt = dm_wdata;
            if (if_req) starve_nxt = starve_cnt + 1'b1;
          end else begin
            own_dm_nxt    = 1'b0;
            lat_we_nxt    = 1'b0;
            lat_addr_nxt  = if_addr;
            lat_wdata_nxt = '0;
            starve_nxt    = '0;
          end
        end
      end
      ISSUE: begin
        state_nxt = WAIT;
        cnt_nxt   = CNT_W'(MEM_LAT - 1);
      end
      WAIT: begin
        if (cnt == '0) state_nxt = RESP;
        else           cnt_nxt   = cnt - 1'b1;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are computed for the next cycle and registered above.
  always_comb begin
    mem_en_nxt    = (state_nxt == ISSUE);
    mem_we_nxt    = mem_en_nxt && lat_we_nxt;
    mem_addr_nxt  = mem_en_nxt ? lat_addr_nxt  : '0;
    mem_wdata_nxt = mem_en_nxt ? lat_wdata_nxt : '0;
    if_gnt_nxt    = mem_en_nxt && !own_dm_nxt;
    dm_gnt_nxt    = mem_en_nxt &&  own_dm_nxt;
    if_valid_nxt  = (state_nxt == RESP) && !own_dm_nxt;
    dm_valid_nxt  = (state_nxt == RESP) &&  own_dm_nxt;
    busy_nxt      = (state_nxt != IDLE);
    if_rdata_nxt  = if_rdata;
    dm_rdata_nxt  = dm_rdata;
    if (state == WAIT && cnt == '0) begin
      if (!own_dm)     if_rdata_nxt = mem_rdata;
      else if (!lat_we) dm_rdata_nxt = mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: a table of single transactions on two instances (MEM_LAT=2 and 1),
// plus hand-written starvation and mid-access reset sequences.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;

  logic        if_gnt0, if_valid0, dm_gnt0, dm_valid0, mem_en0, mem_we0, busy0;
  logic [31:0] if_rdata0, dm_rdata0, mem_addr0, mem_wdata0;
  logic        if_gnt1, if_valid1, dm_gnt1, dm_valid1, mem_en1, mem_we1, busy1;
  logic [31:0] if_rdata1, dm_rdata1, mem_addr1, mem_wdata1;

  logic        o_if_gnt, o_if_valid, o_dm_gnt, o_dm_valid, o_mem_en, o_mem_we, o_busy;
  logic [31:0] o_if_rdata, o_dm_rdata, o_mem_addr, o_mem_wdata;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_if_rd [2];
  logic [31:0] exp_dm_rd [2];

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)) dut0 (
    .clk(clk), .reset(reset),
    .if_req(if_req & ~sel), .if_addr(if_addr), .if_gnt(if_gnt0), .if_valid(if_valid0),
    .if_rdata(if_rdata0),
    .dm_req(dm_req & ~sel), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt0), .dm_valid(dm_valid0), .dm_rdata(dm_rdata0),
    .mem_en(mem_en0), .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
    .mem_rdata(mem_rdata), .busy(busy0)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) dut1 (
    .clk(clk), .reset(reset),
    .if_req(if_req & sel), .if_addr(if_addr), .if_gnt(if_gnt1), .if_valid(if_valid1),
    .if_rdata(if_rdata1),
    .dm_req(dm_req & sel), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt1), .dm_valid(dm_valid1), .dm_rdata(dm_rdata1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata), .busy(busy1)
  );

  assign o_if_gnt    = sel ? if_gnt1    : if_gnt0;
  assign o_if_valid  = sel ? if_valid1  : if_valid0;
  assign o_if_rdata  = sel ? if_rdata1  : if_rdata0;
  assign o_dm_gnt    = sel ? dm_gnt1    : dm_gnt0;
  assign o_dm_valid  = sel ? dm_valid1  : dm_valid0;
  assign o_dm_rdata  = sel ? dm_rdata1  : dm_rdata0;
  assign o_mem_en    = sel ? mem_en1    : mem_en0;
  assign o_mem_we    = sel ? mem_we1    : mem_we0;
  assign o_mem_addr  = sel ? mem_addr1  : mem_addr0;
  assign o_mem_wdata = sel ? mem_wdata1 : mem_wdata0;
  assign o_busy      = sel ? busy1      : busy0;

  typedef struct {
    logic        sel;
    int          lat;
    logic        is_dm;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem_data;
    logic        exp_mem_we;
    logic [31:0] exp_mem_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_access(input vec_t v);
    @(posedge clk); #1;
    sel = v.sel;
    mem_rdata = ~v.mem_data;
    if (v.is_dm) begin
      dm_req = 1'b1; dm_we = v.we; dm_addr = v.addr; dm_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    end
    @(posedge clk); #1;
    // inputs moving after the sampling edge must not reach the memory port
    dm_we = ~dm_we; dm_addr = ~dm_addr; dm_wdata = ~dm_wdata;
    @(negedge clk);
    chk("issue_if_gnt", o_if_gnt, !v.is_dm);
    chk("issue_dm_gnt", o_dm_gnt, v.is_dm);
    chk("issue_mem_en", o_mem_en, 1);
    chk("issue_mem_we", o_mem_we, v.exp_mem_we);
    chk("issue_mem_addr", o_mem_addr, v.addr);
    chk("issue_mem_wdata", o_mem_wdata, v.exp_mem_wdata);
    chk("issue_busy", o_busy, 1);
    for (int c = 2; c <= v.lat + 1; c++) begin
      @(posedge clk); #1;
      mem_rdata = (c == v.lat + 1) ? v.mem_data : ~v.mem_data;
      @(negedge clk);
      chk("wait_mem_en", o_mem_en, 0);
      chk("wait_mem_addr", o_mem_addr, 0);
      chk("wait_valid", {o_if_valid, o_dm_valid}, 0);
      chk("wait_busy", o_busy, 1);
    end
    @(posedge clk); #1;
    mem_rdata = ~v.mem_data;
    @(negedge clk);
    chk("resp_if_valid", o_if_valid, !v.is_dm);
    chk("resp_dm_valid", o_dm_valid, v.is_dm);
    chk("resp_gnt", {o_if_gnt, o_dm_gnt}, 0);
    chk("resp_busy", o_busy, 1);
    if (v.is_dm) begin
      chk("resp_dm_rdata", o_dm_rdata, v.exp_rdata);
      chk("resp_if_rdata_kept", o_if_rdata, exp_if_rd[v.sel]);
      exp_dm_rd[v.sel] = v.exp_rdata;
    end else begin
      chk("resp_if_rdata", o_if_rdata, v.exp_rdata);
      chk("resp_dm_rdata_kept", o_dm_rdata, exp_dm_rd[v.sel]);
      exp_if_rd[v.sel] = v.exp_rdata;
    end
    @(posedge clk); #1;
    if_req = 1'b0; dm_req = 1'b0;
    @(negedge clk);
    chk("idle_busy", o_busy, 0);
    chk("idle_valid", {o_if_valid, o_dm_valid}, 0);
  endtask

  // exp_seq bit i: 1 = DM grant expected, 0 = IF grant expected
  task automatic collect(input int n, input logic [15:0] exp_seq);
    int last = -1;
    int cyc = 0;
    for (int i = 0; i < n; i++) begin
      int waited = 0;
      bit got = 0;
      while (!got && waited < 20) begin
        @(negedge clk);
        cyc++; waited++;
        if (o_if_gnt || o_dm_gnt) got = 1;
      end
      if (!got) begin
        chk("grant_timeout", 0, 1);
        return;
      end
      chk("grant_exclusive", o_if_gnt & o_dm_gnt, 0);
      chk("grant_owner", o_dm_gnt, exp_seq[i]);
      if (last >= 0) chk("issue_gap", cyc - last, 5);
      last = cyc;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    vecs[0] = '{1'b0, 2, 1'b0, 1'b0, 32'h0000_0040, 32'h0, 32'h8C22_0004, 1'b0, 32'h0, 32'h8C22_0004};
    vecs[1] = '{1'b0, 2, 1'b1, 1'b0, 32'h0000_0020, 32'h1111_1111, 32'h1234_5678, 1'b0, 32'h1111_1111, 32'h1234_5678};
    vecs[2] = '{1'b0, 2, 1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'hAAAA_5555, 1'b1, 32'hDEAD_BEEF, 32'h1234_5678};
    vecs[3] = '{1'b0, 2, 1'b0, 1'b0, 32'h0000_0044, 32'h0, 32'h0000_0013, 1'b0, 32'h0, 32'h0000_0013};
    vecs[4] = '{1'b0, 2, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'hCAFE_F00D, 1'b0, 32'h0, 32'hCAFE_F00D};
    vecs[5] = '{1'b1, 1, 1'b0, 1'b0, 32'h0000_0080, 32'h0, 32'h0BAD_C0DE, 1'b0, 32'h0, 32'h0BAD_C0DE};
    vecs[6] = '{1'b1, 1, 1'b1, 1'b0, 32'h0000_0084, 32'h0, 32'h7654_3210, 1'b0, 32'h0, 32'h7654_3210};
    vecs[7] = '{1'b1, 1, 1'b1, 1'b1, 32'h0000_0088, 32'h0F0F_0F0F, 32'h5A5A_5A5A, 1'b1, 32'h0F0F_0F0F, 32'h7654_3210};
    for (int i = 0; i < 2; i++) begin
      exp_if_rd[i] = '0;
      exp_dm_rd[i] = '0;
    end

    reset = 1'b0; sel = 1'b0;
    if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
    #12;
    chk("reset_busy", o_busy, 0);
    chk("reset_mem_en", o_mem_en, 0);
    chk("reset_if_rdata", o_if_rdata, 0);
    chk("reset_dm_rdata", o_dm_rdata, 0);
    @(posedge clk); #1;
    reset = 1'b1;

    for (int i = 0; i < 8; i++) do_access(vecs[i]);

    // Starvation: both held, with a DM-only stretch that must not move the counter.
    @(posedge clk); #1;
    sel = 1'b0; dm_we = 1'b0; dm_addr = 32'h100; if_addr = 32'h200;
    mem_rdata = 32'h55AA_55AA;
    if_req = 1'b1; dm_req = 1'b1;
    collect(2, 16'b11);
    if_req = 1'b0;
    collect(3, 16'b111);
    if_req = 1'b1;
    collect(3, 16'b011);
    collect(5, 16'b01111);
    if_req = 1'b0; dm_req = 1'b0;
    repeat (8) @(negedge clk);
    chk("starve_if_rdata", o_if_rdata, 32'h55AA_55AA);
    chk("starve_dm_rdata", o_dm_rdata, 32'h55AA_55AA);

    // Reset in the middle of WAIT drops the access.
    @(posedge clk); #1;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h30;
    @(posedge clk);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("arst_busy", o_busy, 0);
    chk("arst_mem_en", o_mem_en, 0);
    chk("arst_mem_addr", o_mem_addr, 0);
    chk("arst_valid_gnt", {o_if_valid, o_dm_valid, o_if_gnt, o_dm_gnt}, 0);
    chk("arst_if_rdata", o_if_rdata, 0);
    chk("arst_dm_rdata", o_dm_rdata, 0);
    dm_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    bad = 0;
    repeat (15) begin
      @(negedge clk);
      if (o_if_valid || o_dm_valid || o_busy || o_mem_en) bad++;
    end
    chk("post_reset_quiet", bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
